parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Controller for one shared barrier lane used by both entering and leaving vehicles.
//  Takes clean one-cycle entry/exit request pulses from the upstream Debounce stage.
//  Arbitrates between the two requesters, sequences the barrier (open/pass/close) and
//  owns the free-space counter plus the green/red availability lamps for the lot.
// PARAMETERS
//  CAPACITY      20   total spaces; free-space counter reset value and upper bound
//  CNT_W         5    width of spaces counter; must satisfy CAPACITY < 2**CNT_W
//  OPEN_CYCLES   50   max cycles gate stays open waiting for pass_sensor before timeout
//  CLOSE_CYCLES  10   cycles gate is held closed (lockout) before the next grant
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  entry_req    in   1      one-cycle pulse: vehicle waiting to enter
//  exit_req     in   1      one-cycle pulse: vehicle waiting to leave
//  pass_sensor  in   1      high while vehicle is in the barrier loop
//  gate_open    out  1      barrier raise command
//  grant_entry  out  1      one-cycle pulse: entry request won arbitration
//  grant_exit   out  1      one-cycle pulse: exit request won arbitration
//  spaces       out  CNT_W  free spaces, 0..CAPACITY
//  lot_green    out  1      spaces > 0
//  lot_red      out  1      spaces == 0
//  busy         out  1      FSM not in IDLE
//  timeout_err  out  1      one-cycle pulse: gate opened, no vehicle passed
// BEHAVIOUR
//  Reset values: spaces=CAPACITY, lot_green=1, lot_red=0, gate_open=0, grant_*=0, busy=0,
//   timeout_err=0, both pending flags clear, FSM=IDLE, timer=0, rr_last=ENTRY (exit wins first tie).
//  Reset mid-operation: takes effect on the next edge from any state; gate drops at once;
//   pending flags and any in-flight count update are discarded.
//  Pending flags: one per direction, one deep. A req pulse sets its flag at the next edge.
//   A pulse while the flag is already set is dropped. The flag clears on the edge that grants it.
//  Exit pending with spaces==CAPACITY: discarded in IDLE (flag cleared, no grant).
//  Entry pending with spaces==0: stays pending and is granted once spaces>0.
//  Eligibility, evaluated in IDLE only:
//   entry_ok = entry_pend & (spaces>0); exit_ok = exit_pend & (spaces<CAPACITY).
//  Arbitration: one eligible -> it wins. Both eligible -> round-robin: the winner is the
//   direction not served last (rr_last). rr_last updates on every grant.
//  FSM states: IDLE, OPEN, CLOSING.
//   IDLE->OPEN on a grant. In the same edge: grant_<dir>=1 for one cycle, gate_open=1,
//    timer=0, served direction recorded.
//   OPEN: gate_open=1 and the timer increments. pass_sensor sampled high -> CLOSING and a
//    count update on that edge: entry -> spaces-1, exit -> spaces+1.
//   OPEN timeout: timer==OPEN_CYCLES-1 with no pass -> CLOSING, timeout_err pulse,
//    spaces unchanged.
//   CLOSING: gate_open=0; held CLOSE_CYCLES cycles, then IDLE.
//  Latency: req pulse at edge N -> pending at N -> grant and gate_open at edge N+1 (if IDLE).
//  Requests during OPEN/CLOSING are latched as pending and served after return to IDLE.
//  spaces never wraps: guarded by eligibility, re-checked at the pass edge (saturate at 0/CAPACITY).
//  lot_green/lot_red are combinational from spaces.
//  pass_sensor is ignored outside OPEN.
// TESTING (sim params CAPACITY=20, OPEN_CYCLES=8, CLOSE_CYCLES=4)
//  1 reset, single entry_req, pass_sensor 3 cycles after grant -> grant_entry 1 pulse,
//    gate_open 3 cycles, spaces 20->19, IDLE after 4 closed cycles
//  2 entry_req and exit_req same cycle with spaces=10 -> grant_exit first, then grant_entry;
//    spaces ends 10; next tie -> grant_exit again (rr)
//  3 20 entry cycles -> spaces=0, lot_red=1; further entry_req -> no grant; then exit cycle
//    -> spaces=1 and the pending entry is granted
//  4 exit_req at spaces=20 -> no grant, flag cleared, spaces stays 20
//  5 grant, pass_sensor never asserted -> timeout_err after 8 open cycles, spaces unchanged
//  6 reset asserted while OPEN with exit pending -> gate_open=0, spaces=20, no later grant

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit barrier lane controller: round-robin arbitration between one-deep
// pending requests, open/pass/close sequencing, and the free-space counter with lot lamps.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY     = 20,
  parameter int unsigned CNT_W        = 5,
  parameter int unsigned OPEN_CYCLES  = 50,
  parameter int unsigned CLOSE_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req_i,
  input  logic             exit_req_i,
  input  logic             pass_sensor_i,
  output logic             gate_open_o,
  output logic             grant_entry_o,
  output logic             grant_exit_o,
  output logic [CNT_W-1:0] spaces_o,
  output logic             lot_green_o,
  output logic             lot_red_o,
  output logic             busy_o,
  output logic             timeout_err_o
);

  localparam int unsigned TimerMax = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  localparam logic [CNT_W-1:0]  Full      = CNT_W'(CAPACITY);
  localparam logic [TimerW-1:0] OpenLast  = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] CloseLast = TimerW'(CLOSE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StOpen, StClosing} state_e;
  typedef enum logic {DirEntry, DirExit} dir_e;

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  spaces_q, spaces_d;
  logic              entry_pend_q, entry_pend_d;
  logic              exit_pend_q, exit_pend_d;
  logic              grant_entry_q, grant_entry_d;
  logic              grant_exit_q, grant_exit_d;
  logic              timeout_q, timeout_d;

  logic entry_ok, exit_ok;

  assign entry_ok = entry_pend_q && (spaces_q != '0);
  assign exit_ok  = exit_pend_q && (spaces_q < Full);

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    timer_d       = timer_q;
    spaces_d      = spaces_q;
    // A pulse while the flag is already set simply merges into it.
    entry_pend_d  = entry_pend_q | entry_req_i;
    exit_pend_d   = exit_pend_q | exit_req_i;
    grant_entry_d = 1'b0;
    grant_exit_d  = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Nobody can leave an empty lot: drop the stale exit request.
        if (exit_pend_q && (spaces_q >= Full)) begin
          exit_pend_d = 1'b0;
        end
        if (entry_ok && (!exit_ok || (dir_q == DirExit))) begin
          grant_entry_d = 1'b1;
          entry_pend_d  = 1'b0;
          dir_d         = DirEntry;
          state_d       = StOpen;
          timer_d       = '0;
        end else if (exit_ok) begin
          grant_exit_d = 1'b1;
          exit_pend_d  = 1'b0;
          dir_d        = DirExit;
          state_d      = StOpen;
          timer_d      = '0;
        end
      end

      StOpen: begin
        if (pass_sensor_i) begin
          state_d = StClosing;
          timer_d = '0;
          if (dir_q == DirEntry) begin
            if (spaces_q != '0) spaces_d = spaces_q - CNT_W'(1);
          end else begin
            if (spaces_q < Full) spaces_d = spaces_q + CNT_W'(1);
          end
        end else if (timer_q == OpenLast) begin
          state_d   = StClosing;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StClosing: begin
        if (timer_q == CloseLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      dir_q         <= DirEntry;
      timer_q       <= '0;
      spaces_q      <= Full;
      entry_pend_q  <= 1'b0;
      exit_pend_q   <= 1'b0;
      grant_entry_q <= 1'b0;
      grant_exit_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      timer_q       <= timer_d;
      spaces_q      <= spaces_d;
      entry_pend_q  <= entry_pend_d;
      exit_pend_q   <= exit_pend_d;
      grant_entry_q <= grant_entry_d;
      grant_exit_q  <= grant_exit_d;
      timeout_q     <= timeout_d;
    end
  end

  assign gate_open_o   = (state_q == StOpen);
  assign busy_o        = (state_q != StIdle);
  assign grant_entry_o = grant_entry_q;
  assign grant_exit_o  = grant_exit_q;
  assign timeout_err_o = timeout_q;
  assign spaces_o      = spaces_q;
  assign lot_green_o   = (spaces_q != '0);
  assign lot_red_o     = (spaces_q == '0);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: a per-cycle vector table for the basic flows
// plus hand-written sequences for arbitration, full-lot and mid-operation reset cases.
module tb_parking_gate_arbiter;

  localparam int unsigned Cap = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_req_i = 1'b0;
  logic       exit_req_i = 1'b0;
  logic       pass_sensor_i = 1'b0;
  logic       gate_open_o, grant_entry_o, grant_exit_o;
  logic [4:0] spaces_o;
  logic       lot_green_o, lot_red_o, busy_o, timeout_err_o;

  int checks = 0;
  int errors = 0;
  int exp_sp = Cap;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .CAPACITY    (Cap),
    .CNT_W       (5),
    .OPEN_CYCLES (8),
    .CLOSE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .entry_req_i  (entry_req_i),
    .exit_req_i   (exit_req_i),
    .pass_sensor_i(pass_sensor_i),
    .gate_open_o  (gate_open_o),
    .grant_entry_o(grant_entry_o),
    .grant_exit_o (grant_exit_o),
    .spaces_o     (spaces_o),
    .lot_green_o  (lot_green_o),
    .lot_red_o    (lot_red_o),
    .busy_o       (busy_o),
    .timeout_err_o(timeout_err_o)
  );

  typedef struct {
    bit rst, en, ex, ps;
    bit gate, ge, gx;
    int sp;
    bit busy, terr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, en, ex, ps, gate, ge, gx, input int sp, input bit busy, terr);
    vec_t v;
    v.rst = rst; v.en = en; v.ex = ex; v.ps = ps;
    v.gate = gate; v.ge = ge; v.gx = gx; v.sp = sp; v.busy = busy; v.terr = terr;
    vecs.push_back(v);
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input bit rst, en, ex, ps);
    reset = rst; entry_req_i = en; exit_req_i = ex; pass_sensor_i = ps;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input bit g, ge, gx, input int sp, input bit b, te);
    logic [11:0] act, want;
    act  = {gate_open_o, grant_entry_o, grant_exit_o, spaces_o, lot_green_o, lot_red_o,
            busy_o, timeout_err_o};
    want = {g, ge, gx, 5'(sp), (sp != 0), (sp == 0), b, te};
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b (gate,ge,gx,spaces,green,red,busy,terr)", tag, act, want);
    end
  endtask

  task automatic wait_grant(input bit want_exit, input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(0, 0, 0, 0);
      if (grant_entry_o || grant_exit_o) seen = 1;
    end
    checks++;
    if (!seen || grant_exit_o !== want_exit || grant_entry_o !== !want_exit || !gate_open_o) begin
      errors++;
      $display("FAIL %s grant: got ge=%b gx=%b gate=%b want ge=%b gx=%b gate=1",
               tag, grant_entry_o, grant_exit_o, gate_open_o, !want_exit, want_exit);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy_o; i++) step(0, 0, 0, 0);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got busy=%b want 0", tag, busy_o);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    bit any = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0);
      if (grant_entry_o || grant_exit_o || gate_open_o) any = 1;
    end
    checks++;
    if (any) begin
      errors++;
      $display("FAIL %s: got a grant/open want none", tag);
    end
  endtask

  // Wait for a grant, drive the vehicle through immediately, then wait out the lockout.
  task automatic serve(input bit is_exit, input string tag);
    wait_grant(is_exit, 30, tag);
    step(0, 0, 0, 1);
    exp_sp = is_exit ? exp_sp + 1 : exp_sp - 1;
    chk({tag, " pass"}, 0, 0, 0, exp_sp, 1, 0);
    wait_idle(30, tag);
  endtask

  task automatic full_cycle(input bit is_exit, input string tag);
    step(0, !is_exit, is_exit, 0);
    serve(is_exit, tag);
  endtask

  initial begin
    // Reset, then entry with pass sampled on the 3rd edge after the grant.
    add(1,0,0,0, 0,0,0,20,0,0);
    add(1,0,0,0, 0,0,0,20,0,0);
    add(0,1,0,0, 0,0,0,20,0,0);
    add(0,0,0,0, 1,1,0,20,1,0);
    add(0,0,0,0, 1,0,0,20,1,0);
    add(0,0,0,0, 1,0,0,20,1,0);
    add(0,0,0,1, 0,0,0,19,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,19,1,0);
    add(0,0,0,0, 0,0,0,19,0,0);
    // Exit cycle back to full.
    add(0,0,1,0, 0,0,0,19,0,0);
    add(0,0,0,0, 1,0,1,19,1,0);
    add(0,0,0,1, 0,0,0,20,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, 0,0,0,20,1,0);
    add(0,0,0,0, 0,0,0,20,0,0);
    // Exit request with a full lot is discarded.
    add(0,0,1,0, 0,0,0,20,0,0);
    add(0,0,0,0, 0,0,0,20,0,0);
    add(0,0,0,0, 0,0,0,20,0,0);
    // Entry granted, vehicle never arrives: 8 open cycles then timeout.
    add(0,1,0,0, 0,0,0,20,0,0);
    add(0,0,0,0, 1,1,0,20,1,0);
    for (int i = 0; i < 7; i++) add(0,0,0,0, 1,0,0,20,1,0);
    add(0,0,0,0, 0,0,0,20,1,1);
    add(0,0,0,1, 0,0,0,20,1,0);   // pass while closing is ignored
    for (int i = 0; i < 2; i++) add(0,0,0,0, 0,0,0,20,1,0);
    add(0,0,0,0, 0,0,0,20,0,0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].ex, vecs[i].ps);
      chk($sformatf("vec%0d", i), vecs[i].gate, vecs[i].ge, vecs[i].gx, vecs[i].sp,
          vecs[i].busy, vecs[i].terr);
    end
    exp_sp = Cap;

    // Down to 10 spaces; last served is entry, so the tie goes to exit first.
    for (int i = 0; i < 10; i++) full_cycle(0, $sformatf("fill%0d", i));
    step(0, 1, 1, 0);
    serve(1, "tie1_exit");
    serve(0, "tie1_entry");
    step(0, 1, 1, 0);
    serve(1, "tie2_exit");
    serve(0, "tie2_entry");
    chk("tie_end", 0, 0, 0, 10, 0, 0);

    // Fill the lot; a held entry waits until an exit frees a space.
    for (int i = 0; i < 10; i++) full_cycle(0, $sformatf("fill%0d", 10 + i));
    chk("lot_full", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    quiet(6, "full_entry_held");
    full_cycle(1, "free_one");
    serve(0, "held_entry");
    chk("refull", 0, 0, 0, 0, 0, 0);

    // Reset while open with both directions pending.
    step(0, 0, 1, 0);
    wait_grant(1, 10, "pre_reset");
    step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    exp_sp = Cap;
    chk("reset_mid", 0, 0, 0, 20, 0, 0);
    quiet(20, "after_reset");
    chk("after_reset_sp", 0, 0, 0, 20, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
